normalisation_stage: RTL and testbench

// - Post-add normalisation stage of the accelerator's floating-point MAC/adder datapath.
// - Takes the 20-bit two's-complement sum of exponent-aligned mantissas and the shared (max) exponent.
// - Produces sign, an 11-bit normalised mantissa (hidden 1 at bit 10) and an adjusted 7-bit exponent.
// - Registered output, one pipeline stage; the packer/output stage consumes it.

---
 rtl/normalisation_stage.sv | 107 ++++++++++
 tb/tb_normalisation_stage.sv | 97 +++++++++
 2 files changed

// File: rtl/normalisation_stage.sv
// rtl/normalisation_stage.sv - post-add normalisation: abs, leading-one detect, shift, exponent adjust.
// Optional NORM_ROUND_EN enables round-to-nearest-even; the default build truncates.
module normalisation_stage #(
  parameter int SUM_W   = 20,
  parameter int EXP_W   = 6,
  parameter int MAN_W   = 11,
  parameter int REF_POS = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SUM_W-1:0] signed_sum,
  input  logic [EXP_W-1:0] exp_max,
  output logic             sign,
  output logic [MAN_W-1:0] norm_sum,
  output logic [EXP_W:0]   exp_final
);

  localparam int PW = $clog2(SUM_W);
  // Two spare bits above the output exponent: one for overflow detect, one for sign.
  localparam int EW = EXP_W + 3;
  localparam logic [PW-1:0] HID = PW'(MAN_W - 1);

  logic             sign_q, sign_d;
  logic [MAN_W-1:0] norm_q, norm_d;
  logic [EXP_W:0]   exp_q, exp_d;

  logic             neg;
  logic [SUM_W-1:0] mag;
  logic [PW-1:0]    lead;
  logic [MAN_W-1:0] man;
  logic [EW-1:0]    exp_raw;
`ifdef NORM_ROUND_EN
  logic [PW-1:0]    gpos;
  logic [SUM_W-1:0] low_mask;
  logic             guard, sticky, rnd_up;
  logic [MAN_W:0]   man_rnd;
`endif

  always_comb begin
    neg  = signed_sum[SUM_W-1];
    mag  = neg ? (~signed_sum + SUM_W'(1)) : signed_sum;
    lead = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (mag[i]) lead = PW'(i);
    end

    if (lead >= HID) man = MAN_W'(mag >> (lead - HID));
    else             man = MAN_W'(mag << (HID - lead));

    exp_raw = EW'(exp_max) + EW'(lead) - EW'(REF_POS);

`ifdef NORM_ROUND_EN
    gpos     = '0;
    low_mask = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    rnd_up   = 1'b0;
    man_rnd  = '0;
    if (lead > HID) begin
      gpos     = lead - PW'(MAN_W);
      low_mask = (SUM_W'(1) << gpos) - SUM_W'(1);
      guard    = mag[gpos];
      sticky   = |(mag & low_mask);
      rnd_up   = guard & (sticky | man[0]);
      man_rnd  = {1'b0, man} + (MAN_W+1)'(rnd_up);
      // Carry out of the mantissa renormalises to 1.0 with one more exponent step.
      if (man_rnd[MAN_W]) begin
        man     = MAN_W'(1) << (MAN_W - 1);
        exp_raw = exp_raw + EW'(1);
      end else begin
        man = man_rnd[MAN_W-1:0];
      end
    end
`endif

    sign_d = neg;
    norm_d = man;
    exp_d  = exp_raw[EXP_W:0];
    if (mag == '0) begin
      sign_d = 1'b0;
      norm_d = '0;
      exp_d  = '0;
    end else if (exp_raw[EW-1]) begin
      norm_d = '0;
      exp_d  = '0;
    end else if (exp_raw[EW-2]) begin
      exp_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      norm_q <= '0;
      exp_q  <= '0;
    end else begin
      sign_q <= sign_d;
      norm_q <= norm_d;
      exp_q  <= exp_d;
    end
  end

  assign sign      = sign_q;
  assign norm_sum  = norm_q;
  assign exp_final = exp_q;

endmodule

// File: tb/tb_normalisation_stage.sv
// tb/tb_normalisation_stage.sv - directed-vector bench for normalisation_stage (NORM_ROUND_EN aware).
module tb_normalisation_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] signed_sum;
  logic [5:0]  exp_max;
  logic        sign;
  logic [10:0] norm_sum;
  logic [6:0]  exp_final;

  int n_checks = 0;
  int n_errors = 0;

  normalisation_stage dut (
    .clk        (clk),
    .rst        (rst),
    .signed_sum (signed_sum),
    .exp_max    (exp_max),
    .sign       (sign),
    .norm_sum   (norm_sum),
    .exp_final  (exp_final)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [19:0] s, input logic [5:0] e,
                     input logic es, input logic [10:0] en, input logic [6:0] ee);
    @(negedge clk);
    signed_sum = s;
    exp_max    = e;
    @(posedge clk);
    #1;
    check({tag, ".sign"}, 32'(sign), 32'(es));
    check({tag, ".norm"}, 32'(norm_sum), 32'(en));
    check({tag, ".exp"},  32'(exp_final), 32'(ee));
  endtask

  initial begin
    rst        = 1'b1;
    signed_sum = 20'h1C71C;
    exp_max    = 6'd55;
    @(posedge clk);
    #1;
    check("rst.sign", 32'(sign), 32'd0);
    check("rst.norm", 32'(norm_sum), 32'd0);
    check("rst.exp",  32'(exp_final), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("unit17",   20'h20000, 6'd15, 1'b0, 11'h400, 7'd15);
    run("unit18",   20'h40000, 6'd15, 1'b0, 11'h400, 7'd16);
    run("neg17",    20'hE0000, 6'd15, 1'b1, 11'h400, 7'd15);
    run("mixed",    20'h1C71C, 6'd55, 1'b0, 11'h71C, 7'd54);
    run("uflow",    20'h00001, 6'd3,  1'b0, 11'h000, 7'd0);
    run("zero",     20'h00000, 6'd40, 1'b0, 11'h000, 7'd0);
    run("lsh6",     20'h00010, 6'd40, 1'b0, 11'h400, 7'd27);
    run("lsh2",     20'h00123, 6'd30, 1'b0, 11'h48C, 7'd21);
    run("maxneg",   20'h80000, 6'd10, 1'b1, 11'h400, 7'd12);
    run("minus1",   20'hFFFFF, 6'd20, 1'b1, 11'h400, 7'd3);
    run("uflowneg", 20'hFFFFF, 6'd3,  1'b1, 11'h000, 7'd0);
`ifdef NORM_ROUND_EN
    run("rnd_up",   20'h200C0, 6'd15, 1'b0, 11'h402, 7'd15);
    run("rnd_tie",  20'h20040, 6'd15, 1'b0, 11'h400, 7'd15);
    run("rnd_cy",   20'h3FFC0, 6'd15, 1'b0, 11'h400, 7'd16);
    run("rnd_max",  20'h7FFFF, 6'd63, 1'b0, 11'h400, 7'd65);
`else
    run("trunc1",   20'h200C0, 6'd15, 1'b0, 11'h401, 7'd15);
    run("trunc2",   20'h20040, 6'd15, 1'b0, 11'h400, 7'd15);
    run("trunc3",   20'h3FFC0, 6'd15, 1'b0, 11'h7FF, 7'd15);
    run("truncmax", 20'h7FFFF, 6'd63, 1'b0, 11'h7FF, 7'd64);
`endif

    // Reset must win over valid data mid-stream.
    @(negedge clk);
    rst        = 1'b1;
    signed_sum = 20'h40000;
    exp_max    = 6'd20;
    @(posedge clk);
    #1;
    check("rst2.sign", 32'(sign), 32'd0);
    check("rst2.norm", 32'(norm_sum), 32'd0);
    check("rst2.exp",  32'(exp_final), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
